// File: rtl/cpu_pkg.sv
// Shared definitions for the NPC core: sequencer state encoding and decoder branch codes.
package cpu_pkg;

   typedef enum logic [2:0] {
      FETCH  = 3'd0,
      F_WAIT = 3'd1,
      DECODE = 3'd2,
      EXEC   = 3'd3,
      M_REQ  = 3'd4,
      M_WAIT = 3'd5,
      WB     = 3'd6,
      HALT   = 3'd7
   } state_e;

   localparam logic [2:0] BR_NONE = 3'b000;
   localparam logic [2:0] BR_JAL  = 3'b001;
   localparam logic [2:0] BR_JALR = 3'b010;
   localparam logic [2:0] BR_BEQ  = 3'b100;
   localparam logic [2:0] BR_BNE  = 3'b101;
   localparam logic [2:0] BR_BLT  = 3'b110;
   localparam logic [2:0] BR_BGE  = 3'b111;

   // States that wait on a memory handshake and are therefore guarded by the watchdog.
   function automatic logic is_wait_state(state_e s);
      return (s == FETCH) || (s == F_WAIT) || (s == M_REQ) || (s == M_WAIT);
   endfunction

endpackage

// File: rtl/seq_wdog.sv
// Wait-state watchdog: counts cycles spent in one state, flags the last permitted cycle.
module seq_wdog #(
   parameter int unsigned TIMEOUT_CYCLES = 1024
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_clr,
   input  logic i_en,
   output logic o_expired
);

   localparam int unsigned W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [W-1:0] LAST = W'(TIMEOUT_CYCLES - 1);

   logic [W-1:0] r_cnt;

   // Saturates at LAST so a stalled count can never wrap back to a "fresh" value.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n || i_clr) begin
         r_cnt <= '0;
      end else if (i_en && (r_cnt != LAST)) begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   assign o_expired = (r_cnt == LAST);

endmodule

// File: rtl/cpu_seq_ctrl.sv
// Multi-cycle instruction sequencer: drives IFU/LSU handshakes, gates decoder write requests,
// and keeps halt/timeout status plus cycle and retired-instruction counters.
module cpu_seq_ctrl
   import cpu_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 1024,
   parameter int unsigned CNT_W          = 64
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   output logic             o_ifu_req_valid,
   input  logic             i_ifu_req_ready,
   input  logic             i_ifu_rsp_valid,
   output logic             o_ifu_rsp_ready,
   output logic             o_ir_we,
   input  logic             i_dec_RegWr,
   input  logic             i_dec_MemtoReg,
   input  logic             i_dec_MemWr,
   input  logic [2:0]       i_dec_Branch,
   input  logic             i_is_ebreak,
   output logic             o_lsu_req_valid,
   output logic             o_lsu_req_wr,
   input  logic             i_lsu_req_ready,
   input  logic             i_lsu_rsp_valid,
   output logic             o_lsu_rsp_ready,
   output logic             o_rf_we,
   output logic             o_pc_we,
   output logic             o_halt,
   output logic             o_timeout,
   output logic [CNT_W-1:0] o_cycle_cnt,
   output logic [CNT_W-1:0] o_instret_cnt,
   output logic [2:0]       o_state_dbg
);

   state_e             r_state;
   state_e             w_state_nxt;
   logic               w_to_fire;
   logic               w_expired;
   logic               w_retire;
   logic               r_timeout;
   logic [CNT_W-1:0]   r_cycle_cnt;
   logic [CNT_W-1:0]   r_instret_cnt;
   logic               w_unused_branch;

   // The next-PC mux in the datapath consumes the branch code; the sequencer strobes pc_we only.
   assign w_unused_branch = ^i_dec_Branch;

   seq_wdog #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_wdog (
      .i_clk    (i_clk),
      .i_rst_n  (i_rst_n),
      .i_clr    (w_state_nxt != r_state),
      .i_en     (is_wait_state(r_state)),
      .o_expired(w_expired)
   );

   assign w_retire = (r_state == WB) || ((r_state == DECODE) && i_is_ebreak);

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_state       <= FETCH;
         r_timeout     <= 1'b0;
         r_cycle_cnt   <= '0;
         r_instret_cnt <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (w_to_fire) r_timeout <= 1'b1;
         if (r_state != HALT) r_cycle_cnt <= r_cycle_cnt + 1'b1;
         if (w_retire) r_instret_cnt <= r_instret_cnt + 1'b1;
      end
   end

   // A handshake completing on the last permitted cycle takes priority over the timeout.
   always_comb begin
      w_state_nxt = r_state;
      w_to_fire   = 1'b0;
      case (r_state)
         FETCH: begin
            if (i_ifu_req_ready) w_state_nxt = F_WAIT;
            else if (w_expired) w_to_fire = 1'b1;
         end
         F_WAIT: begin
            if (i_ifu_rsp_valid) w_state_nxt = DECODE;
            else if (w_expired) w_to_fire = 1'b1;
         end
         DECODE:  w_state_nxt = i_is_ebreak ? HALT : EXEC;
         EXEC:    w_state_nxt = (i_dec_MemtoReg || i_dec_MemWr) ? M_REQ : WB;
         M_REQ: begin
            if (i_lsu_req_ready) w_state_nxt = M_WAIT;
            else if (w_expired) w_to_fire = 1'b1;
         end
         M_WAIT: begin
            if (i_lsu_rsp_valid) w_state_nxt = WB;
            else if (w_expired) w_to_fire = 1'b1;
         end
         WB:      w_state_nxt = FETCH;
         HALT:    w_state_nxt = HALT;
         default: w_state_nxt = HALT;
      endcase
      if (w_to_fire) w_state_nxt = HALT;
   end

   always_comb begin
      o_ifu_req_valid = 1'b0;
      o_ifu_rsp_ready = 1'b0;
      o_ir_we         = 1'b0;
      o_lsu_req_valid = 1'b0;
      o_lsu_req_wr    = 1'b0;
      o_lsu_rsp_ready = 1'b0;
      o_rf_we         = 1'b0;
      o_pc_we         = 1'b0;
      case (r_state)
         FETCH:  o_ifu_req_valid = 1'b1;
         F_WAIT: begin
            o_ifu_rsp_ready = 1'b1;
            o_ir_we         = i_ifu_rsp_valid;
         end
         M_REQ: begin
            o_lsu_req_valid = 1'b1;
            o_lsu_req_wr    = i_dec_MemWr;
         end
         M_WAIT: o_lsu_rsp_ready = 1'b1;
         WB: begin
            o_rf_we = i_dec_RegWr;
            o_pc_we = 1'b1;
         end
         default: ;
      endcase
   end

   assign o_halt        = (r_state == HALT);
   assign o_timeout     = r_timeout;
   assign o_cycle_cnt   = r_cycle_cnt;
   assign o_instret_cnt = r_instret_cnt;
   assign o_state_dbg   = r_state;

endmodule

// File: tb/tb_cpu_seq_ctrl.sv
// Self-checking bench for cpu_seq_ctrl: table vectors, random instructions against a cycle model,
// and hand-written ebreak, timeout and mid-transaction reset sequences.
module tb_cpu_seq_ctrl;

   localparam int unsigned TO = 1024;

   logic        clk = 1'b0;
   logic        i_rst_n;
   logic        o_ifu_req_valid, i_ifu_req_ready, i_ifu_rsp_valid, o_ifu_rsp_ready, o_ir_we;
   logic        i_dec_RegWr, i_dec_MemtoReg, i_dec_MemWr, i_is_ebreak;
   logic [2:0]  i_dec_Branch;
   logic        o_lsu_req_valid, o_lsu_req_wr, i_lsu_req_ready, i_lsu_rsp_valid, o_lsu_rsp_ready;
   logic        o_rf_we, o_pc_we, o_halt, o_timeout;
   logic [63:0] o_cycle_cnt, o_instret_cnt;
   logic [2:0]  o_state_dbg;

   always #5 clk = ~clk;

   cpu_seq_ctrl #(
      .TIMEOUT_CYCLES(TO),
      .CNT_W         (64)
   ) dut (
      .i_clk          (clk),
      .i_rst_n        (i_rst_n),
      .o_ifu_req_valid(o_ifu_req_valid),
      .i_ifu_req_ready(i_ifu_req_ready),
      .i_ifu_rsp_valid(i_ifu_rsp_valid),
      .o_ifu_rsp_ready(o_ifu_rsp_ready),
      .o_ir_we        (o_ir_we),
      .i_dec_RegWr    (i_dec_RegWr),
      .i_dec_MemtoReg (i_dec_MemtoReg),
      .i_dec_MemWr    (i_dec_MemWr),
      .i_dec_Branch   (i_dec_Branch),
      .i_is_ebreak    (i_is_ebreak),
      .o_lsu_req_valid(o_lsu_req_valid),
      .o_lsu_req_wr   (o_lsu_req_wr),
      .i_lsu_req_ready(i_lsu_req_ready),
      .i_lsu_rsp_valid(i_lsu_rsp_valid),
      .o_lsu_rsp_ready(o_lsu_rsp_ready),
      .o_rf_we        (o_rf_we),
      .o_pc_we        (o_pc_we),
      .o_halt         (o_halt),
      .o_timeout      (o_timeout),
      .o_cycle_cnt    (o_cycle_cnt),
      .o_instret_cnt  (o_instret_cnt),
      .o_state_dbg    (o_state_dbg)
   );

   typedef struct {
      bit          regwr;
      bit          memtoreg;
      bit          memwr;
      int unsigned d_ireq;
      int unsigned d_irsp;
      int unsigned d_lreq;
      int unsigned d_lrsp;
      int unsigned exp_cycles;
      int unsigned exp_rf;
      int unsigned exp_lreqv;
   } vec_t;

   int          n_tests = 0;
   int          n_fail  = 0;
   longint unsigned m_cycles, m_instret;
   int          res_cyc, res_rf, res_rf_at, res_pc, res_lreqv, res_code, res_wrbad;
   bit          res_done;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual %0d required %0d", name, act, exp);
      end
   endtask

   task automatic clear_hs();
      i_ifu_req_ready = 1'b0;
      i_ifu_rsp_valid = 1'b0;
      i_lsu_req_ready = 1'b0;
      i_lsu_rsp_valid = 1'b0;
   endtask

   function automatic logic [7:0] strobes();
      return {o_ifu_req_valid, o_ifu_rsp_ready, o_ir_we, o_lsu_req_valid, o_lsu_req_wr,
              o_lsu_rsp_ready, o_rf_we, o_pc_we};
   endfunction

   // Leaves the bench at the negedge of the first FETCH cycle after reset.
   task automatic do_reset();
      i_rst_n = 1'b0;
      clear_hs();
      {i_dec_RegWr, i_dec_MemtoReg, i_dec_MemWr, i_is_ebreak} = 4'b0;
      i_dec_Branch = 3'b000;
      repeat (2) @(negedge clk);
      chk("rst_state", o_state_dbg, 0);
      chk("rst_outputs", {strobes(), o_halt, o_timeout}, 10'b10_0000_0000);
      chk("rst_cycle_cnt", o_cycle_cnt, 0);
      chk("rst_instret_cnt", o_instret_cnt, 0);
      i_rst_n = 1'b1;
      m_cycles  = 0;
      m_instret = 0;
   endtask

   // Memory responders: each ready/valid is raised after the given number of waiting cycles.
   task automatic run_instr(input vec_t v);
      int ic = 0, rc = 0, lc = 0, sc = 0;
      i_dec_RegWr    = v.regwr;
      i_dec_MemtoReg = v.memtoreg;
      i_dec_MemWr    = v.memwr;
      i_dec_Branch   = 3'($urandom_range(0, 7));
      i_is_ebreak    = 1'b0;
      {res_cyc, res_rf, res_rf_at, res_pc, res_lreqv, res_code, res_wrbad} = '0;
      res_done = 1'b0;
      while (!res_done && res_cyc < 200) begin
         clear_hs();
         if (o_ifu_req_valid) begin i_ifu_req_ready = (ic == v.d_ireq); ic++; end
         if (o_ifu_rsp_ready) begin i_ifu_rsp_valid = (rc == v.d_irsp); rc++; end
         if (o_lsu_req_valid) begin
            i_lsu_req_ready = (lc == v.d_lreq);
            lc++;
            res_lreqv++;
            if (o_lsu_req_wr !== v.memwr) res_wrbad++;
         end
         if (o_lsu_rsp_ready) begin i_lsu_rsp_valid = (sc == v.d_lrsp); sc++; end
         #1;
         res_code = res_code * 8 + int'(o_state_dbg);
         if (o_rf_we) begin res_rf++; res_rf_at = res_cyc; end
         if (o_pc_we) begin res_pc++; res_done = 1'b1; end
         res_cyc++;
         @(negedge clk);
      end
      clear_hs();
      chk("instr_completed", res_done, 1);
   endtask

   function automatic int unsigned model_cycles(input vec_t v);
      int unsigned mem = (v.memtoreg || v.memwr) ? (v.d_lreq + 1) + (v.d_lrsp + 1) : 0;
      return (v.d_ireq + 1) + (v.d_irsp + 1) + 2 + mem + 1;
   endfunction

   task automatic check_instr(input string tag, input vec_t v);
      run_instr(v);
      m_cycles  += v.exp_cycles;
      m_instret += 1;
      chk({tag, "_cycles"}, res_cyc, v.exp_cycles);
      chk({tag, "_rf_we_pulses"}, res_rf, v.exp_rf);
      if (v.exp_rf != 0) chk({tag, "_rf_we_in_wb"}, res_rf_at, v.exp_cycles - 1);
      chk({tag, "_pc_we_pulses"}, res_pc, 1);
      chk({tag, "_lsu_req_valid_cycles"}, res_lreqv, v.exp_lreqv);
      chk({tag, "_lsu_req_wr"}, res_wrbad, 0);
      chk({tag, "_cycle_cnt"}, o_cycle_cnt, m_cycles);
      chk({tag, "_instret_cnt"}, o_instret_cnt, m_instret);
      chk({tag, "_back_to_fetch"}, o_state_dbg, 0);
   endtask

   initial begin
      #3_000_000;
      $display("FAIL global_time_limit: actual expired required finish");
      $fatal(1);
   end

   initial begin
      vec_t tab[6];
      vec_t v;
      bit   bad;
      //            rw mr mw  ireq irsp lreq lrsp  cyc rf lreqv
      tab[0] = '{1, 0, 0, 0, 0, 0, 0, 5,  1, 0};  // ADDI, zero wait
      tab[1] = '{0, 0, 1, 0, 0, 3, 0, 10, 0, 4};  // SW, lsu_req_ready 3 cycles late
      tab[2] = '{1, 1, 0, 0, 0, 0, 4, 11, 1, 1};  // LW, lsu_rsp_valid late
      tab[3] = '{0, 0, 0, 2, 1, 0, 0, 8,  0, 0};  // branch, slow fetch
      tab[4] = '{1, 1, 0, 1, 1, 1, 1, 11, 1, 2};  // LW, every wait 1
      tab[5] = '{0, 0, 1, 0, 0, 0, 0, 7,  0, 1};  // SW, zero wait

      do_reset();
      for (int i = 0; i < 6; i++) begin
         check_instr($sformatf("vec%0d", i), tab[i]);
         if (i == 0) chk("vec0_state_trace", res_code, 32'o1236);
      end

      for (int i = 0; i < 40; i++) begin
         int unsigned kind = $urandom_range(0, 3);
         v.regwr    = (kind == 0) || (kind == 2);
         v.memtoreg = (kind == 2);
         v.memwr    = (kind == 3);
         v.d_ireq   = $urandom_range(0, 4);
         v.d_irsp   = $urandom_range(0, 4);
         v.d_lreq   = $urandom_range(0, 4);
         v.d_lrsp   = $urandom_range(0, 4);
         v.exp_cycles = model_cycles(v);
         v.exp_rf     = v.regwr ? 1 : 0;
         v.exp_lreqv  = (v.memtoreg || v.memwr) ? v.d_lreq + 1 : 0;
         check_instr($sformatf("rnd%0d", i), v);
      end

      // ebreak: HALT two cycles after ir_we, then everything frozen
      i_is_ebreak     = 1'b1;
      i_ifu_req_ready = 1'b1;
      @(negedge clk);
      i_ifu_req_ready = 1'b0;
      i_ifu_rsp_valid = 1'b1;
      #1 chk("ebrk_ir_we", o_ir_we, 1);
      @(negedge clk);
      i_ifu_rsp_valid = 1'b0;
      chk("ebrk_decode_state", o_state_dbg, 2);
      @(negedge clk);
      chk("ebrk_halt", o_halt, 1);
      chk("ebrk_timeout", o_timeout, 0);
      chk("ebrk_state", o_state_dbg, 7);
      chk("ebrk_instret", o_instret_cnt, m_instret + 1);
      chk("ebrk_cycle_cnt", o_cycle_cnt, m_cycles + 3);
      bad = 1'b0;
      for (int i = 0; i < 100; i++) begin
         {i_ifu_req_ready, i_ifu_rsp_valid, i_lsu_req_ready, i_lsu_rsp_valid} = 4'($urandom);
         #1;
         if (strobes() != 8'h00 || o_cycle_cnt != m_cycles + 3 || !o_halt) bad = 1'b1;
         @(negedge clk);
      end
      chk("ebrk_frozen_100", bad, 0);

      // fetch response never arrives: halt with timeout after TO waiting cycles
      do_reset();
      i_ifu_req_ready = 1'b1;
      @(negedge clk);
      i_ifu_req_ready = 1'b0;
      for (int i = 0; i < int'(TO); i++) begin
         if (i == int'(TO) - 1) chk("to_still_waiting_last_cycle", o_state_dbg, 1);
         @(negedge clk);
      end
      chk("to_halt", o_halt, 1);
      chk("to_timeout", o_timeout, 1);
      chk("to_state", o_state_dbg, 7);

      // response on the last permitted cycle: handshake wins
      do_reset();
      i_ifu_req_ready = 1'b1;
      @(negedge clk);
      i_ifu_req_ready = 1'b0;
      repeat (TO - 1) @(negedge clk);
      i_ifu_rsp_valid = 1'b1;
      #1 chk("to_edge_ir_we", o_ir_we, 1);
      @(negedge clk);
      i_ifu_rsp_valid = 1'b0;
      chk("to_edge_state", o_state_dbg, 2);
      chk("to_edge_no_halt", {o_halt, o_timeout}, 0);

      // reset while a load waits in M_WAIT
      do_reset();
      i_dec_RegWr     = 1'b1;
      i_dec_MemtoReg  = 1'b1;
      i_ifu_req_ready = 1'b1;
      @(negedge clk);
      i_ifu_req_ready = 1'b0;
      i_ifu_rsp_valid = 1'b1;
      @(negedge clk);
      i_ifu_rsp_valid = 1'b0;
      repeat (2) @(negedge clk);
      i_lsu_req_ready = 1'b1;
      @(negedge clk);
      i_lsu_req_ready = 1'b0;
      @(negedge clk);
      chk("mrst_in_mwait", {o_state_dbg, o_lsu_rsp_ready}, {3'd5, 1'b1});
      i_rst_n = 1'b0;
      @(negedge clk);
      i_rst_n = 1'b1;
      i_lsu_rsp_valid = 1'b1;
      #1;
      chk("mrst_state", o_state_dbg, 0);
      chk("mrst_cycle_cnt", o_cycle_cnt, 0);
      chk("mrst_instret_cnt", o_instret_cnt, 0);
      chk("mrst_lsu_rsp_ready", o_lsu_rsp_ready, 0);
      @(negedge clk);
      i_lsu_rsp_valid = 1'b0;
      chk("mrst_late_rsp_ignored", o_state_dbg, 0);
      chk("mrst_rf_we", o_rf_we, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
